// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the run-state encoding, digit width, default MM:SS moduli and load saturation.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DIGIT_W = 4;

  localparam logic [15:0] MMSS_MODULI = 16'h6A6A;

  // A preset field at or above the modulus clamps to the largest legal digit.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] v,
                                                   input logic [DIGIT_W-1:0] m);
    logic [DIGIT_W-1:0] r;
    if (v >= m) begin
      r = m - 4'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of modulus MOD.
// Supports a saturating load and a borrow decrement that wraps 0 -> MOD-1.
module bcd_digit
  import bcd_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MOD = 4'd10
) (
  input  logic               clock,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  input  logic               dec,
  output logic [DIGIT_W-1:0] q,
  output logic               is_zero
);

  logic [DIGIT_W-1:0] q_d;
  logic [DIGIT_W-1:0] q_q;

  // Next digit value: load beats decrement.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = sat_digit(d, MOD);
    end else if (dec) begin
      if (q_q == 4'd0) begin
        q_d = MOD - 4'd1;
      end else begin
        q_d = q_q - 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Digit register with synchronous clear.
  always_ff @(posedge clock) begin
    if (clr) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign is_zero = (q_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: cascaded digits with borrow ripple,
// run/pause state machine, stop-at-zero or wrap mode and a registered done pulse.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int                          NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0]     MODULI     = MMSS_MODULI
) (
  input  logic                          clock,
  input  logic                          clr,
  input  logic                          loadn,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          wrap_mode,
  input  logic                          enable,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic                          zero,
  output logic                          tc,
  output logic                          done,
  output logic                          running
);

  state_e                          state_d, state_q;
  logic                            done_d, done_q;
  logic [DIGIT_W*NUM_DIGITS-1:0]   digit_q_s;
  logic [NUM_DIGITS-1:0]           is_zero_s;
  logic [NUM_DIGITS:0]             lower_zero_s;
  logic [NUM_DIGITS-1:0]           dec_s;
  logic                            zero_s;
  logic                            count_one_s;
  logic                            running_s;
  logic                            tick_s;

  // Borrow chain and "count equals one" detection from the pre-edge digits.
  always_comb begin
    lower_zero_s[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lower_zero_s[i+1] = lower_zero_s[i] & is_zero_s[i];
    end
    count_one_s = (digit_q_s[DIGIT_W-1:0] == 4'd1);
    for (int i = 1; i < NUM_DIGITS; i++) begin
      count_one_s = count_one_s & is_zero_s[i];
    end
  end

  assign zero_s    = lower_zero_s[NUM_DIGITS];
  assign running_s = (state_q == ST_RUN);
  // A zero count in stop mode must not wrap; it only moves the FSM to DONE.
  assign tick_s    = running_s & enable & loadn & ~pause & (wrap_mode | ~zero_s);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign dec_s[g] = tick_s & lower_zero_s[g];

    bcd_digit #(
      .MOD (MODULI[DIGIT_W*g +: DIGIT_W])
    ) u_digit (
      .clock   (clock),
      .clr     (clr),
      .load    (~loadn),
      .d       (data[DIGIT_W*g +: DIGIT_W]),
      .dec     (dec_s[g]),
      .q       (digit_q_s[DIGIT_W*g +: DIGIT_W]),
      .is_zero (is_zero_s[g])
    );
  end

  // Run-state next-state and done pulse; load overrides everything but clr.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (!loadn) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSED: begin
          if (!pause && start && (!zero_s || wrap_mode)) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (enable && !wrap_mode && (zero_s || count_one_s)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state and done registers.
  always_ff @(posedge clock) begin
    if (clr) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign digits  = digit_q_s;
  assign zero    = zero_s;
  assign running = running_s;
  assign tc      = zero_s & enable & running_s;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: a mixed-radix integer model predicts
// each edge; monitors pop and compare registered outputs and the tc strobe.
module tb_bcd_countdown_timer;

  localparam int          ND   = 4;
  localparam logic [15:0] MODS = 16'h6A6A;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

  logic        clock = 1'b0;
  logic        clr = 1'b1, loadn = 1'b1, start = 1'b0, pause = 1'b0;
  logic        wrap_mode = 1'b0, enable = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [15:0] digits;
  logic        zero, tc, done, running;

  bcd_countdown_timer #(.NUM_DIGITS(ND), .MODULI(MODS)) dut (
    .clock(clock), .clr(clr), .loadn(loadn), .data(data), .start(start),
    .pause(pause), .wrap_mode(wrap_mode), .enable(enable), .digits(digits),
    .zero(zero), .tc(tc), .done(done), .running(running)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] dig;
    logic        dn;
    logic        run;
    logic        zr;
  } exp_t;

  exp_t exp_q[$];
  int   tc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_val = 0;
  int   m_state = S_IDLE;
  bit   m_valid = 1'b0;

  function automatic int modulus(input int i);
    logic [15:0] t;
    t = MODS >> (4 * i);
    return int'(t[3:0]);
  endfunction

  function automatic int max_val();
    int p;
    p = 1;
    for (int i = 0; i < ND; i++) p = p * modulus(i);
    return p - 1;
  endfunction

  function automatic int to_val(input logic [15:0] d);
    int v, w, f;
    v = 0;
    w = 1;
    for (int i = 0; i < ND; i++) begin
      f = int'(d[4*i +: 4]);
      if (f >= modulus(i)) f = modulus(i) - 1;
      v = v + f * w;
      w = w * modulus(i);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_digits(input int v);
    logic [15:0] r;
    int          x;
    r = 16'h0000;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % modulus(i));
      x = x / modulus(i);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  // One clock of stimulus; the model predicts tc now and the registers after the edge.
  task automatic drive(input bit c, input bit l_n, input logic [15:0] d,
                       input bit s, input bit p, input bit w, input bit e);
    exp_t x;
    bit   dn;
    @(negedge clock);
    clr = c; loadn = l_n; data = d; start = s; pause = p; wrap_mode = w; enable = e;
    if (m_valid) tc_q.push_back((m_state == S_RUN && e && m_val == 0) ? 1 : 0);
    else tc_q.push_back(-1);
    dn = 1'b0;
    if (c) begin
      m_val = 0; m_state = S_IDLE; m_valid = 1'b1;
    end else if (!l_n) begin
      m_val = to_val(d); m_state = S_IDLE;
    end else if (m_state == S_RUN) begin
      if (p) m_state = S_PAUSED;
      else if (e) begin
        if (m_val == 0) begin
          if (w) m_val = max_val();
          else begin m_state = S_DONE; dn = 1'b1; end
        end else begin
          m_val = m_val - 1;
          if (m_val == 0 && !w) begin m_state = S_DONE; dn = 1'b1; end
        end
      end
    end else if (m_state == S_IDLE || m_state == S_PAUSED) begin
      if (!p && s && (m_val != 0 || w)) m_state = S_RUN;
    end
    x.dig = to_digits(m_val);
    x.dn  = dn;
    x.run = (m_state == S_RUN);
    x.zr  = (m_val == 0);
    exp_q.push_back(x);
  endtask

  // Registered-output monitor.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("digits",  32'(digits),  32'(x.dig));
        check("done",    32'(done),    32'(x.dn));
        check("running", 32'(running), 32'(x.run));
        check("zero",    32'(zero),    32'(x.zr));
      end
    end
  end

  // Combinational tc monitor, sampled once inputs have settled.
  initial begin
    int t;
    forever begin
      @(negedge clock);
      #2;
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        if (t >= 0) check("tc", 32'(tc), 32'(t));
      end
    end
  end

  initial begin
    bit          c, l_n, s, p, w, e;
    logic [15:0] d;
    drive(1, 1, 16'h0000, 0, 0, 0, 0);
    drive(1, 1, 16'h0000, 0, 0, 0, 0);
    // 01:00 -> 00:59
    drive(0, 0, 16'h0100, 0, 0, 0, 0);
    drive(0, 1, 16'h0000, 1, 0, 0, 0);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    // stop mode reaching zero, then ticks and start in DONE
    drive(0, 0, 16'h0002, 0, 0, 0, 0);
    drive(0, 1, 16'h0000, 1, 0, 0, 0);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    drive(0, 1, 16'h0000, 1, 0, 0, 0);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    // wrap at zero
    drive(0, 0, 16'h0000, 0, 0, 1, 0);
    drive(0, 1, 16'h0000, 1, 0, 1, 0);
    drive(0, 1, 16'h0000, 0, 0, 1, 1);
    drive(0, 1, 16'h0000, 0, 0, 1, 0);
    // pause beats start, ticks ignored while paused, resume
    drive(0, 0, 16'h0100, 0, 0, 0, 0);
    drive(0, 1, 16'h0000, 1, 0, 0, 0);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    drive(0, 1, 16'h0000, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 16'h0000, 0, 0, 0, 1);
    drive(0, 1, 16'h0000, 1, 0, 0, 0);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    // saturating load, then clr mid-run
    drive(0, 0, 16'hFF9C, 0, 0, 0, 0);
    drive(0, 1, 16'h0000, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 16'h0000, 0, 0, 0, 1);
    drive(1, 1, 16'h0000, 0, 0, 0, 1);
    drive(0, 1, 16'h0000, 0, 0, 0, 0);
    // start at zero in stop mode is ignored; wrap 1->0 while running at zero
    drive(0, 0, 16'h0000, 0, 0, 0, 0);
    drive(0, 1, 16'h0000, 1, 0, 0, 0);
    drive(0, 1, 16'h0000, 1, 0, 1, 0);
    drive(0, 1, 16'h0000, 0, 0, 1, 0);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    drive(0, 1, 16'h0000, 0, 0, 0, 1);
    // randomized traffic biased toward small presets so zero is reached often
    for (int n = 0; n < 600; n++) begin
      c   = ($urandom_range(0, 99) < 2);
      l_n = ($urandom_range(0, 15) != 0);
      d   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      s   = ($urandom_range(0, 5) == 0);
      p   = ($urandom_range(0, 19) == 0);
      w   = ($urandom_range(0, 3) == 0);
      e   = ($urandom_range(0, 1) == 1);
      drive(c, l_n, d, s, p, w, e);
    end
    drive(0, 1, 16'h0000, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    check("drain_exp", 32'(exp_q.size()), 32'd0);
    check("drain_tc",  32'(tc_q.size()),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
